// File: rtl/dmem_burst_responder_pkg.sv
// Shared types and constants for the word-to-line burst responder and its line merge helper.
// A line is BEATS beats of BEAT_W bits; beat k holds line bytes [8k+7:8k].
package dmem_burst_pkg;

    localparam int BEATS       = 4;
    localparam int BEAT_W      = 64;
    localparam int LINE_BYTES  = 32;
    localparam int OFFSET_BITS = 5;

    typedef logic [BEAT_W-1:0]  beat_t;
    typedef beat_t [BEATS-1:0]  line_t;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        MERGE,
        WB,
        RESP
    } state_e;

endpackage

// File: rtl/dmem_burst_responder_if.sv
// CPU word port plus burst-memory port of the responder, bundled as one interface.
// The slave modport is the responder's view; master is the CPU/memory side.
interface dmem_burst_responder_if;
    import dmem_burst_pkg::*;

    logic [31:0]       mem_address;
    logic [3:0]        mem_rmask;
    logic [3:0]        mem_wmask;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_resp;

    logic [31:0]       bmem_address;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_resp;

    modport master (
        output mem_address, mem_rmask, mem_wmask, mem_wdata,
        input  mem_rdata, mem_resp,
        input  bmem_address, bmem_read, bmem_write, bmem_wdata,
        output bmem_rdata, bmem_resp
    );

    modport slave (
        input  mem_address, mem_rmask, mem_wmask, mem_wdata,
        output mem_rdata, mem_resp,
        output bmem_address, bmem_read, bmem_write, bmem_wdata,
        input  bmem_rdata, bmem_resp
    );

endinterface

// File: rtl/dmem_burst_responder_line_merge.sv
// Combinational byte-masked merge of one 32-bit word into a cache line.
// Word widx occupies line bits [widx*32 +: 32], i.e. beat widx[2:1], half widx[0].
module line_merge
    import dmem_burst_pkg::*;
(
    input  line_t       line_i,
    input  logic [2:0]  widx_i,
    input  logic [3:0]  wmask_i,
    input  logic [31:0] wdata_i,
    output line_t       line_o
);

    logic [BEATS*BEAT_W-1:0] flat;

    always_comb begin
        flat = line_i;
        for (int b = 0; b < 4; b++) begin
            if (wmask_i[b]) begin
                flat[{widx_i, 5'b0} + 8'(b * 8) +: 8] = wdata_i[8*b +: 8];
            end
        end
        line_o = flat;
    end

endmodule

// File: rtl/dmem_burst_responder.sv
// Word-granular CPU memory port served by whole-line bursts, no caching.
// Reads fill a line; writes fill, merge the masked bytes, then write the line back.
module dmem_burst_responder
    import dmem_burst_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    dmem_burst_responder_if.slave bus
);

    state_e                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    line_t                   line_q, line_d;
    logic                    isWrite_q, isWrite_d;
    logic [2:0]              widx_q, widx_d;

    line_t                   mergedLine;
    logic [BEATS*BEAT_W-1:0] lineFlat;
    logic [31:0]             lineAddr;
    logic                    lastBeat;
    logic                    unusedAddrBits;

    logic [31:0]             memRdata;
    logic                    memResp;
    logic [31:0]             bmemAddress;
    logic                    bmemRead;
    logic                    bmemWrite;
    logic [BEAT_W-1:0]       bmemWdata;

    assign lineFlat       = line_q;
    assign lineAddr       = {bus.mem_address[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign lastBeat       = (cnt_q == 2'(BEATS - 1));
    assign unusedAddrBits = ^bus.mem_address[1:0];

    line_merge u_line_merge (
        .line_i  (line_q),
        .widx_i  (widx_q),
        .wmask_i (bus.mem_wmask),
        .wdata_i (bus.mem_wdata),
        .line_o  (mergedLine)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            line_q    <= '0;
            isWrite_q <= 1'b0;
            widx_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            line_q    <= line_d;
            isWrite_q <= isWrite_d;
            widx_q    <= widx_d;
        end
    end

    // Outputs decode from state only, so an async reset silences the bus immediately.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        line_d      = line_q;
        isWrite_d   = isWrite_q;
        widx_d      = widx_q;
        memRdata    = '0;
        memResp     = 1'b0;
        bmemAddress = '0;
        bmemRead    = 1'b0;
        bmemWrite   = 1'b0;
        bmemWdata   = '0;

        case (state_q)
            IDLE: begin
                if ((bus.mem_rmask | bus.mem_wmask) != 4'b0) begin
                    isWrite_d = (bus.mem_wmask != 4'b0);
                    widx_d    = bus.mem_address[4:2];
                    state_d   = FILL;
                end
            end
            FILL: begin
                bmemRead    = 1'b1;
                bmemAddress = lineAddr;
                if (bus.bmem_resp) begin
                    line_d[cnt_q] = bus.bmem_rdata;
                    if (lastBeat) begin
                        cnt_d   = '0;
                        state_d = isWrite_q ? MERGE : RESP;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            MERGE: begin
                line_d  = mergedLine;
                state_d = WB;
            end
            WB: begin
                bmemWrite   = 1'b1;
                bmemAddress = lineAddr;
                bmemWdata   = line_q[cnt_q];
                if (bus.bmem_resp) begin
                    if (lastBeat) begin
                        cnt_d   = '0;
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            RESP: begin
                memResp  = 1'b1;
                memRdata = lineFlat[{widx_q, 5'b0} +: 32];
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_rdata    = memRdata;
    assign bus.mem_resp     = memResp;
    assign bus.bmem_address = bmemAddress;
    assign bus.bmem_read    = bmemRead;
    assign bus.bmem_write   = bmemWrite;
    assign bus.bmem_wdata   = bmemWdata;

endmodule
